// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate definitions: source-type encoding, per-type field masks
// and the representability check used by the immediate encoder.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    // Representable when every bit above the field's sign bit matches it; B/J must be even.
    function automatic logic imm_in_range(input imm_src_t src, input logic [31:0] imm);
        logic ok;
        ok = 1'b0;
        case (src)
            IMM_I, IMM_S: ok = (&imm[31:11]) | ~(|imm[31:11]);
            IMM_B:        ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            IMM_J:        ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters an immediate into the I/S/B/J field layout and
// merges it into a base instruction word. Upper immediate bits are truncated.
module imm_pack
    import riscv_pkg::*;
(
    input  imm_src_t    i_src,
    input  logic [20:0] i_imm,
    input  logic [31:0] i_base,
    output logic [31:0] o_instr
);

    logic [31:0] w_fields;
    logic [31:0] w_mask;

    always_comb begin
        w_fields = '0;
        w_mask   = '0;
        case (i_src)
            IMM_I: begin
                w_fields = {i_imm[11:0], 20'b0};
                w_mask   = MASK_I;
            end
            IMM_S: begin
                w_fields = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                w_mask   = MASK_S;
            end
            IMM_B: begin
                w_fields = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
                w_mask   = MASK_B;
            end
            IMM_J: begin
                w_fields = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
                w_mask   = MASK_J;
            end
            default: begin
                w_fields = '0;
                w_mask   = '0;
            end
        endcase
        o_instr = (i_base & ~w_mask) | w_fields;
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 latches the input word and its range check, S2 holds
// the packed instruction streamed out at an auto-incrementing word address.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
    parameter bit                    DROP_ON_ERR = 1'b1,
    parameter int                    ERR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [1:0]            i_imm_src,
    input  logic [31:0]           i_imm,
    input  logic [31:0]           i_base,
    input  logic                  i_addr_clr,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [31:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_imm_err,
    output logic [ERR_WIDTH-1:0]  o_err_count
);

    logic                  r_s1_valid;
    imm_src_t              r_s1_src;
    logic [31:0]           r_s1_imm;
    logic [31:0]           r_s1_base;
    logic                  r_s1_err;

    logic                  r_s2_valid;
    logic [31:0]           r_instr;
    logic                  r_imm_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ERR_WIDTH-1:0]  r_err_count;

    logic                  w_s2_load;
    logic                  w_s1_load;
    logic                  w_s1_keep;
    logic                  w_in_err;
    logic                  w_out_hs;
    logic [31:0]           w_packed;

    assign w_s2_load = ~r_s2_valid | i_out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign w_in_err  = ~imm_in_range(imm_src_t'(i_imm_src), i_imm);
    // An erroring word still drains out of S1 but never becomes a valid S2 word.
    assign w_s1_keep = r_s1_valid & ~(DROP_ON_ERR & r_s1_err);
    assign w_out_hs  = r_s2_valid & i_out_ready;

    imm_pack u_imm_pack (
        .i_src   (r_s1_src),
        .i_imm   (r_s1_imm[20:0]),
        .i_base  (r_s1_base),
        .o_instr (w_packed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= IMM_I;
            r_s1_imm   <= '0;
            r_s1_base  <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= i_in_valid;
            r_s1_src   <= imm_src_t'(i_imm_src);
            r_s1_imm   <= i_imm;
            r_s1_base  <= i_base;
            r_s1_err   <= w_in_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_instr    <= '0;
            r_imm_err  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= w_s1_keep;
            if (w_s1_keep) begin
                r_instr   <= w_packed;
                r_imm_err <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= START_ADDR;
        end else if (i_addr_clr) begin
            r_addr <= START_ADDR;
        end else if (w_out_hs) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_s1_valid && r_s1_err && w_s2_load && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_in_ready  = w_s1_load & ~rst;
    assign o_out_valid = r_s2_valid;
    assign o_instr     = r_instr;
    assign o_imm_err   = r_imm_err;
    assign o_addr      = r_addr;
    assign o_err_count = r_err_count;

endmodule
